// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_stage_pkg;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] ia_plus_4;
    } id_params_t;

    localparam logic [31:0] IA_STEP = 32'd4;

    // Counter width that can hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// IF/ID buffer: synchronous FIFO of id_params_t; flush empties it and wins over push.
module fetch_queue
    import if_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  id_params_t       push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output id_params_t       head
);

    localparam int PTR_W = $clog2(DEPTH);

    id_params_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns IA, issues in-order fetches under a credit limit,
// buffers responses for decode and redirects on a consumed branch.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_IA = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output id_params_t  id_params,
    input  logic        branch_req,
    input  logic [31:0] branch_ia
);

    localparam int             CNT_W   = cnt_width(DEPTH);
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

    logic [31:0]      ia;
    logic [31:0]      rsp_ia;
    logic [31:0]      target;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] in_flight_next;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W:0]   credit_used;
    logic             q_empty;
    logic             q_full;
    logic             req_fire;
    logic             rsp_fire;
    logic             pop;
    logic             redirect;
    logic             push;
    id_params_t       push_data;
    logic             unused_bits;

    assign target      = {branch_ia[31:2], 2'b00};
    assign unused_bits = ^{branch_ia[1:0], q_full};

    assign id_valid = !q_empty;
    assign pop      = id_valid && id_ready;
    assign redirect = branch_req && pop;

    // A slot freed by this cycle's pop may be reissued at once; this keeps
    // one fetch per cycle with single-cycle memory while never overcommitting.
    assign credit_used    = {1'b0, in_flight} + {1'b0, q_count} - {{CNT_W{1'b0}}, pop};
    assign imem_req_valid = !rst && (credit_used < CREDITS);
    assign imem_req_addr  = ia;

    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid;
    assign push           = rsp_fire && (drop_cnt == '0);
    assign push_data      = '{ir: imem_rsp_data, ia_plus_4: rsp_ia + IA_STEP};
    assign in_flight_next = in_flight + CNT_W'(req_fire) - CNT_W'(rsp_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            ia        <= RESET_IA;
            rsp_ia    <= RESET_IA;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            in_flight <= in_flight_next;
            if (redirect) begin
                ia       <= target;
                rsp_ia   <= target;
                drop_cnt <= in_flight_next;
            end else begin
                if (req_fire) begin
                    ia <= ia + IA_STEP;
                end
                if (push) begin
                    rsp_ia <= rsp_ia + IA_STEP;
                end
                if (rsp_fire && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head      (id_params)
    );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: in-order memory model with random latency,
// plus an instruction-stream reference (sequential addresses, jump on consumed branch).
`timescale 1ns/1ps
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_IA = 32'h0000_0100;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    id_params_t  id_params;
    logic        branch_req;
    logic [31:0] branch_ia;

    always #5 clk = ~clk;

    if_stage #(.RESET_IA(RST_IA), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_params      (id_params),
        .branch_req     (branch_req),
        .branch_ia      (branch_ia)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        pend[$];
    int          cyc = 0;
    int          buffered = 0;
    int          delivered = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] exp_req_addr = RST_IA;
    logic [31:0] exp_next_ia = RST_IA;
    int          rdy_pct = 100, idr_pct = 100, br_pct = 0, lat_min = 1, lat_max = 1;
    bit          br_force = 0;
    logic [31:0] br_tgt = '0;
    bit          prev_stall = 0;
    id_params_t  prev_params;
    bit          snap_req_valid, snap_id_valid, snap_fire, snap_pop;
    logic [31:0] snap_req_addr;
    id_params_t  snap_params;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1234_5678;
    endfunction

    // One clock: drive inputs, sample at negedge, check and advance the reference.
    task automatic step();
        req_t        r;
        logic [31:0] tgt;
        bit          redir;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        id_ready       = ($urandom_range(99) < idr_pct);
        if (br_force) begin
            branch_req = 1'b1;
            branch_ia  = br_tgt;
            br_force   = 0;
        end else begin
            branch_req = ($urandom_range(99) < br_pct);
            branch_ia  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15))
                                                  : $urandom_range(32'hFFFF);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end
        @(negedge clk);
        snap_req_valid = imem_req_valid;
        snap_req_addr  = imem_req_addr;
        snap_id_valid  = id_valid;
        snap_params    = id_params;
        snap_pop       = 0;
        snap_fire      = 0;
        if (rst) begin
            n_assert++;
            if (imem_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL req_valid_in_reset: got %b want 0", imem_req_valid);
            end
            pend.delete();
            buffered     = 0;
            exp_req_addr = RST_IA;
            exp_next_ia  = RST_IA;
            prev_stall   = 0;
        end else begin
            if (imem_req_valid) begin
                n_assert++;
                if (imem_req_addr !== exp_req_addr) begin
                    n_fail++;
                    $display("FAIL req_addr @%0d: got %h want %h", cyc, imem_req_addr, exp_req_addr);
                end
            end
            n_assert++;
            if (pend.size() + buffered > DEPTH) begin
                n_fail++;
                $display("FAIL credit @%0d: got %0d want <= %0d", cyc, pend.size() + buffered, DEPTH);
            end
            n_assert++;
            if (id_valid !== (buffered > 0)) begin
                n_fail++;
                $display("FAIL id_valid @%0d: got %b want %b", cyc, id_valid, buffered > 0);
            end
            if (prev_stall) begin
                n_assert++;
                if (id_params !== prev_params) begin
                    n_fail++;
                    $display("FAIL hold @%0d: got %h want %h", cyc, id_params, prev_params);
                end
            end
            snap_pop = id_valid && id_ready;
            redir    = snap_pop && branch_req;
            tgt      = {branch_ia[31:2], 2'b00};
            if (snap_pop) begin
                n_assert++;
                if (id_params.ia_plus_4 !== exp_next_ia + 32'd4) begin
                    n_fail++;
                    $display("FAIL ia_plus_4 @%0d: got %h want %h", cyc, id_params.ia_plus_4, exp_next_ia + 32'd4);
                end
                n_assert++;
                if (id_params.ir !== mem_word(exp_next_ia)) begin
                    n_fail++;
                    $display("FAIL ir @%0d: got %h want %h", cyc, id_params.ir, mem_word(exp_next_ia));
                end
                exp_next_ia = redir ? tgt : exp_next_ia + 32'd4;
                buffered--;
                delivered++;
            end
            if (imem_rsp_valid) begin
                r = pend.pop_front();
                if (!r.stale) buffered++;
            end
            snap_fire = imem_req_valid && imem_req_ready;
            if (snap_fire) begin
                pend.push_back('{addr: imem_req_addr,
                                 due: cyc + int'($urandom_range(lat_max, lat_min)),
                                 stale: 1'b0});
                exp_req_addr = exp_req_addr + 32'd4;
            end
            if (redir) begin
                foreach (pend[i]) pend[i].stale = 1'b1;
                buffered     = 0;
                exp_req_addr = tgt;
            end
            prev_stall  = id_valid && !id_ready;
            prev_params = id_params;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        br_force = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        n_assert++;
        if (snap_id_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_id_valid: got %b want 0", snap_id_valid);
        end
        n_assert++;
        if (snap_params !== '0) begin
            n_fail++;
            $display("FAIL reset_id_params: got %h want 0", snap_params);
        end
        n_assert++;
        if (!snap_req_valid || snap_req_addr !== RST_IA) begin
            n_fail++;
            $display("FAIL reset_req: got valid=%b addr=%h want valid=1 addr=%h", snap_req_valid, snap_req_addr, RST_IA);
        end
    endtask

    task automatic test_stream();
        rdy_pct = 100; idr_pct = 100; br_pct = 0; lat_min = 1; lat_max = 1;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            step();
            if (c < 3) begin
                n_assert++;
                if (!snap_fire || snap_req_addr !== RST_IA + 32'(4 * c)) begin
                    n_fail++;
                    $display("FAIL stream_req c%0d: got fire=%b addr=%h want fire=1 addr=%h", c, snap_fire, snap_req_addr, RST_IA + 32'(4 * c));
                end
            end
            if (c < 2) begin
                n_assert++;
                if (snap_id_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_early_valid c%0d: got %b want 0", c, snap_id_valid);
                end
            end else if (c < 5) begin
                n_assert++;
                if (!snap_id_valid || snap_params.ia_plus_4 !== RST_IA + 32'(4 * (c - 1))) begin
                    n_fail++;
                    $display("FAIL stream_out c%0d: got valid=%b ia_plus_4=%h want 1 %h", c, snap_id_valid, snap_params.ia_plus_4, RST_IA + 32'(4 * (c - 1)));
                end
            end
        end
    endtask

    task automatic test_stall();
        int d0;
        idr_pct = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            n_assert++;
            if (snap_req_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_req_valid k%0d: got %b want 0", k, snap_req_valid);
            end
        end
        d0 = delivered;
        idr_pct = 100;
        for (int k = 0; k < 12; k++) step();
        n_assert++;
        if (delivered - d0 < 8) begin
            n_fail++;
            $display("FAIL stall_resume: got %0d delivered want >= 8", delivered - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        rdy_pct = 100; idr_pct = 100; br_pct = 0; lat_min = 1; lat_max = 1;
        do_reset();
        d0 = delivered;
        for (int k = 0; k < 50; k++) step();
        n_assert++;
        if (delivered - d0 != 48) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d delivered want 48", delivered - d0);
        end
    endtask

    task automatic wait_first_pop(input string name, input logic [31:0] ia);
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (snap_pop) begin
                found = 1;
                n_assert++;
                if (snap_params.ia_plus_4 !== ia + 32'd4 || snap_params.ir !== mem_word(ia)) begin
                    n_fail++;
                    $display("FAIL %s_first: got %h/%h want %h/%h", name, snap_params.ia_plus_4, snap_params.ir, ia + 32'd4, mem_word(ia));
                end
            end
        end
        n_assert++;
        if (!found) begin
            n_fail++;
            $display("FAIL %s_timeout: got no delivery want one within 40 cycles", name);
        end
    endtask

    task automatic test_redirect();
        bit hit = 0;
        rdy_pct = 100; idr_pct = 100; br_pct = 0; lat_min = 2; lat_max = 2;
        do_reset();
        for (int k = 0; k < 20 && !hit; k++) begin
            if (buffered > 0) begin
                br_force = 1; br_tgt = 32'h203; hit = 1;
            end
            step();
        end
        n_assert++;
        if (!snap_pop) begin
            n_fail++;
            $display("FAIL redir_taken: got pop=%b want 1", snap_pop);
        end
        step();
        n_assert++;
        if (snap_req_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_addr: got %h want %h", snap_req_addr, 32'h200);
        end
        wait_first_pop("redir", 32'h200);
    endtask

    task automatic test_redirect_fire();
        bit hit = 0;
        rdy_pct = 100; idr_pct = 100; br_pct = 0; lat_min = 3; lat_max = 3;
        do_reset();
        for (int k = 0; k < 20 && !hit; k++) begin
            if (exp_req_addr == 32'h10C && buffered > 0) begin
                br_force = 1; br_tgt = 32'h200; hit = 1;
            end
            step();
        end
        n_assert++;
        if (!snap_fire || snap_req_addr !== 32'h10C || !snap_pop) begin
            n_fail++;
            $display("FAIL redir_fire: got fire=%b addr=%h pop=%b want 1 10c 1", snap_fire, snap_req_addr, snap_pop);
        end
        wait_first_pop("redir_fire", 32'h200);
    endtask

    task automatic test_req_stall();
        rdy_pct = 100; idr_pct = 0; br_pct = 0; lat_min = 1; lat_max = 1;
        do_reset();
        step();
        rdy_pct = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                idr_pct = 100; br_force = 1; br_tgt = 32'h300;
            end
            step();
            n_assert++;
            if (!snap_req_valid || snap_req_addr !== RST_IA + 32'd4) begin
                n_fail++;
                $display("FAIL req_hold k%0d: got valid=%b addr=%h want 1 %h", k, snap_req_valid, snap_req_addr, RST_IA + 32'd4);
            end
        end
        step();
        n_assert++;
        if (!snap_req_valid || snap_req_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL req_hold_redir: got valid=%b addr=%h want 1 300", snap_req_valid, snap_req_addr);
        end
        rdy_pct = 100;
        wait_first_pop("req_hold", 32'h300);
    endtask

    task automatic test_reset_mid();
        bit full_seen = 0;
        rdy_pct = 100; idr_pct = 0; br_pct = 0; lat_min = 1; lat_max = 1;
        do_reset();
        for (int k = 0; k < 20 && !full_seen; k++) begin
            step();
            full_seen = (buffered == DEPTH);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        n_assert++;
        if (snap_id_valid !== 1'b0 || !snap_req_valid || snap_req_addr !== RST_IA) begin
            n_fail++;
            $display("FAIL reset_mid: got id_valid=%b req=%b/%h want 0 1/%h", snap_id_valid, snap_req_valid, snap_req_addr, RST_IA);
        end
        idr_pct = 100;
        wait_first_pop("reset_mid", RST_IA);
    endtask

    task automatic test_random();
        int d0;
        rdy_pct = 70; idr_pct = 70; br_pct = 8; lat_min = 1; lat_max = 4;
        do_reset();
        d0 = delivered;
        for (int k = 0; k < 3000; k++) step();
        n_assert++;
        if (delivered - d0 < 300) begin
            n_fail++;
            $display("FAIL random_progress: got %0d delivered want >= 300", delivered - d0);
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        id_ready = 1'b0;
        branch_req = 1'b0;
        branch_ia = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_redirect();
        test_redirect_fire();
        test_req_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
